// File: rtl/sipo_word_assembler.sv
// rtl/sipo_word_assembler.sv - serial-in word assembler with double-buffered valid/ready output
// Optional even-parity bit per word when SIPO_PARITY_EN is defined (adds parity_err output).
module sipo_word_assembler #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ser_in,
  input  logic                       ser_en,
  input  logic                       clr,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
`ifdef SIPO_PARITY_EN
  output logic                       parity_err,
`endif
  output logic                       overrun,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next, shifted, done_word;
  logic [CW-1:0]    cnt_next;
  logic             complete;
  logic [WIDTH-1:0] word_next;
  logic             valid_next, overrun_next;
`ifdef SIPO_PARITY_EN
  logic             done_perr, perr_next;
`endif

  always_comb begin
    shifted = sr;
    if (MSB_FIRST != 0) shifted = {sr[WIDTH-2:0], ser_in};
    else                shifted = {ser_in, sr[WIDTH-1:1]};
  end

  // Input side: counts enabled bits and flags the edge on which a word completes.
  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = bit_cnt;
    complete   = 1'b0;
    done_word  = shifted;
`ifdef SIPO_PARITY_EN
    done_perr  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (ser_en) begin
          sr_next    = shifted;
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          sr_next = shifted;
          if (bit_cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
            cnt_next   = CW'(WIDTH);
            state_next = PARITY;
`else
            complete   = 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
`endif
          end else begin
            cnt_next = bit_cnt + CW'(1);
          end
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        // Data bits already sit in sr; the parity bit is only folded into the check.
        if (ser_en) begin
          complete   = 1'b1;
          done_word  = sr;
          done_perr  = ^{sr, ser_in};
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output side: a completed word is dropped rather than overwriting an unconsumed one.
  always_comb begin
    word_next    = word_out;
    valid_next   = word_valid;
    overrun_next = overrun;
`ifdef SIPO_PARITY_EN
    perr_next    = parity_err;
`endif
    if (complete) begin
      if (!word_valid || word_ready) begin
        word_next  = done_word;
        valid_next = 1'b1;
`ifdef SIPO_PARITY_EN
        perr_next  = done_perr;
`endif
      end else begin
        overrun_next = 1'b1;
      end
    end else if (word_valid && word_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= '0;
      bit_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (clr) begin
      sr         <= '0;
      bit_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      sr         <= sr_next;
      bit_cnt    <= cnt_next;
      word_out   <= word_next;
      word_valid <= valid_next;
      overrun    <= overrun_next;
`ifdef SIPO_PARITY_EN
      parity_err <= perr_next;
`endif
    end
  end

endmodule

// File: tb/tb_sipo_word_assembler.sv
// tb/tb_sipo_word_assembler.sv - directed bench for sipo_word_assembler, MSB-first and LSB-first instances
module tb_sipo_word_assembler;

  logic       clk = 1'b0;
  logic       rst, ser_in, ser_en, clr, word_ready;
  logic [7:0] word_out, word_out_l;
  logic       word_valid, word_valid_l, overrun, overrun_l;
  logic [3:0] bit_cnt, bit_cnt_l;
`ifdef SIPO_PARITY_EN
  logic       parity_err, parity_err_l;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_word_assembler #(.WIDTH(8), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .clr(clr),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
`ifdef SIPO_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun), .bit_cnt(bit_cnt)
  );

  sipo_word_assembler #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .clr(clr),
    .word_out(word_out_l), .word_valid(word_valid_l), .word_ready(word_ready),
`ifdef SIPO_PARITY_EN
    .parity_err(parity_err_l),
`endif
    .overrun(overrun_l), .bit_cnt(bit_cnt_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    ser_in = b; ser_en = 1'b1; word_ready = rdy;
    @(posedge clk); #1;
    ser_en = 1'b0; ser_in = 1'b0; word_ready = 1'b0;
  endtask

  // word_ready is raised only on the edge that completes the word.
  task automatic send_word(input logic [7:0] data, input logic rdy);
`ifdef SIPO_PARITY_EN
    for (int i = 0; i < 8; i++) send_bit(data[7-i], 1'b0);
    send_bit(^data, rdy);
`else
    for (int i = 0; i < 8; i++) send_bit(data[7-i], (i == 7) ? rdy : 1'b0);
`endif
  endtask

  task automatic do_clr();
    clr = 1'b1; ser_en = 1'b1; ser_in = 1'b1; word_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; ser_en = 1'b0; ser_in = 1'b0; word_ready = 1'b0;
  endtask

  typedef struct {
    logic       clr_first;
    logic [7:0] data;
    logic       rdy;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] b2;

  initial begin
    vecs[0] = '{1'b1, 8'hB2, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h0F, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 8'h11, 1'b0, 8'h11, 8'h88, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h22, 1'b1, 8'h22, 8'h44, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'hC1, 1'b0, 8'hC1, 8'h83, 1'b1, 1'b0};

    rst = 1'b1; ser_in = 1'b0; ser_en = 1'b0; clr = 1'b0; word_ready = 1'b0;
    #12;
    chk("reset word_out", word_out, 8'h00);
    chk("reset valid", word_valid, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    chk("reset bit_cnt", bit_cnt, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic word with latency and hold checks
    b2 = 8'hB2;
    for (int i = 0; i < 7; i++) send_bit(b2[7-i], 1'b0);
    chk("basic cnt7", bit_cnt, 4'd7);
    chk("basic valid early", word_valid, 1'b0);
    send_bit(b2[0], 1'b0);
`ifdef SIPO_PARITY_EN
    chk("basic cnt parity", bit_cnt, 4'd8);
    chk("basic valid before parity", word_valid, 1'b0);
    send_bit(1'b0, 1'b0);
`endif
    chk("basic valid", word_valid, 1'b1);
    chk("basic word", word_out, 8'hB2);
    chk("basic word lsb", word_out_l, 8'h4D);
    chk("basic cnt0", bit_cnt, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold valid", word_valid, 1'b1);
    chk("hold word", word_out, 8'hB2);
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    chk("consume valid", word_valid, 1'b0);
    chk("consume word kept", word_out, 8'hB2);

    // Asynchronous reset mid-word, then a clean word
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    chk("midword cnt5", bit_cnt, 4'd5);
    #3 rst = 1'b1;
    #1;
    chk("async rst cnt", bit_cnt, 4'd0);
    chk("async rst word", word_out, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    send_word(8'hA5, 1'b0);
    chk("after rst word", word_out, 8'hA5);
    chk("after rst word lsb", word_out_l, 8'hA5);
    chk("after rst cnt", bit_cnt, 4'd0);

    // Gaps: each bit followed by two idle cycles
    do_clr();
    for (int i = 0; i < 8; i++) begin
      send_bit(b2[7-i], 1'b0);
      repeat (2) @(posedge clk);
      #1;
      if (i < 7) chk($sformatf("gap cnt%0d", i), bit_cnt, 32'(i + 1));
    end
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    chk("gap word", word_out, 8'hB2);
    chk("gap valid", word_valid, 1'b1);

    // Table: overrun, clear, back-to-back handoff
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].clr_first) begin
        do_clr();
        chk($sformatf("v%0d clr word", v), word_out, 8'h00);
        chk($sformatf("v%0d clr valid", v), word_valid, 1'b0);
        chk($sformatf("v%0d clr ovr", v), overrun, 1'b0);
      end
      send_word(vecs[v].data, vecs[v].rdy);
      chk($sformatf("v%0d word", v), word_out, vecs[v].exp_msb);
      chk($sformatf("v%0d word lsb", v), word_out_l, vecs[v].exp_lsb);
      chk($sformatf("v%0d valid", v), word_valid, vecs[v].exp_valid);
      chk($sformatf("v%0d ovr", v), overrun, vecs[v].exp_ovr);
      chk($sformatf("v%0d ovr lsb", v), overrun_l, vecs[v].exp_ovr);
    end

`ifdef SIPO_PARITY_EN
    do_clr();
    for (int i = 0; i < 8; i++) send_bit(vecs[4].data[7-i], 1'b0);
    send_bit(1'b0, 1'b0);
    chk("parity ok word", word_out, 8'hA5);
    chk("parity ok err", parity_err, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(vecs[4].data[7-i], 1'b0);
    send_bit(1'b1, 1'b1);
    chk("parity bad word", word_out, 8'hA5);
    chk("parity bad err", parity_err, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_word_assembler.md
Name: sipo_word_assembler

Overview:
- Serial-in, parallel-out word assembler that sits directly downstream of the clocked D-latch stage.
- Samples the latch's Q output one bit per enabled clock and assembles WIDTH-bit words.
- Presents each completed word on a double-buffered valid/ready output port.
- Flags lost words with a sticky overrun bit.

Parameters:
- WIDTH, 8: data bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in word_out[WIDTH-1]; 0 = first received bit lands in word_out[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ser_in  input  1  serial data bit, driven by the latch Q.
- ser_en  input  1  ser_in is sampled on a clk rising edge only when ser_en=1.
- clr  input  1  synchronous clear; highest priority after rst.
- word_out  output  WIDTH  last completed word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when word_valid=1 and word_ready=1.
- overrun  output  1  sticky; a completed word was discarded.
- bit_cnt  output  $clog2(WIDTH+1)  bits currently held in the shift register.

Behaviour:
- Reset: rst=1 asynchronously forces the following; state remains there while rst is held.
  - word_out=0, word_valid=0, overrun=0, bit_cnt=0.
  - Internal shift register = 0.
  - FSM = IDLE.
- clr=1 at a clk edge:
  - Same values as reset, applied synchronously.
  - ser_en and word_ready are ignored in that cycle.
- Shift rules, applied on each edge with ser_en=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], ser_in}.
  - MSB_FIRST=0: sr <= {ser_in, sr[WIDTH-1:1]}.
- Input FSM:
  - IDLE: bit_cnt=0. ser_en=1 -> shift, bit_cnt=1, go to SHIFT.
  - SHIFT, ser_en=1 with bit_cnt<WIDTH-1 -> shift, bit_cnt++.
  - SHIFT, ser_en=1 with bit_cnt=WIDTH-1 -> word completes this edge: the completed word is the shifted value, bit_cnt=0, go to IDLE.
  - SHIFT, ser_en=0 -> hold; no timeout.
- Output buffer (word_out is a separate register from sr):
  - On word completion with word_valid=0: word_out <= completed word; word_valid=1 on the next cycle. Latency is 1 cycle from the WIDTH-th enabled edge.
  - On word completion with word_valid=1 and word_ready=1 (same edge): old word consumed, new word loaded, word_valid stays 1.
  - On word completion with word_valid=1 and word_ready=0: new word discarded, word_out unchanged, overrun <= 1 (sticky until clr or rst).
  - No completion, with word_valid=1 and word_ready=1: word_valid <= 0; word_out keeps its value.
  - word_out and word_valid must not change while word_valid=1 and word_ready=0, except via clr or rst.
- Serial reception continues while word_valid=1; stall on the output side never blocks ser_en.
- word_ready while word_valid=0 has no effect.
- rst asserted mid-word: the partial word is lost and bit_cnt=0 immediately, without waiting for a clock.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each word is WIDTH data bits followed by one even-parity bit.
  - Extra FSM state PARITY is entered at the WIDTH-th data bit, with bit_cnt held at WIDTH.
  - The next enabled bit is the parity bit, which completes the word; FSM returns to IDLE.
  - Extra output port parity_err (1 bit) is loaded alongside word_out: parity_err = XOR(data bits, parity bit).
  - parity_err obeys the same hold/overrun rules as word_out; reset value 0.
- Undefined:
  - No PARITY state and no parity_err port.
  - Words complete after exactly WIDTH bits.

Test Plan:
- Run all scenarios with WIDTH=8 and MSB_FIRST=1 unless noted.
- Reset: rst pulse between clock edges -> all outputs 0 immediately.
- Basic word: shift 1,0,1,1,0,0,1,0 with ser_en=1 each cycle, word_ready=0 -> word_out=8'hB2, word_valid=1 one cycle after the 8th edge, bit_cnt=0. Then word_ready=1 for 1 cycle -> word_valid=0.
- Bit order: repeat the basic-word stimulus with MSB_FIRST=0 -> word_out=8'h4D.
- Gaps: ser_en toggled 1,0,0,1,... across 8 data bits -> same word as gapless; bit_cnt holds its value during gaps.
- Overrun and back-to-back:
  - Words 8'hB2 then 8'h0F sent with word_ready=0 -> word_out stays 8'hB2, overrun=1.
  - Then clr -> all outputs 0.
  - Then 8'h11 and 8'h22 sent with word_ready=1 on the completion edge of 8'h22 -> word_out=8'h22, word_valid stays 1, overrun=0.
- Mid-word reset and parity:
  - rst after 5 bits, then a full word 8'hA5 -> word_out=8'hA5, no leftover bits.
  - With SIPO_PARITY_EN: 8'hA5 with parity bit 0 -> parity_err=0; with parity bit 1 -> parity_err=1.
